uart_rx: RTL and testbench

Serial receiver that turns the host's asynchronous RS-232 line into the byte-wide ready/valid stream consumed by the terminal core (`host_ready`/`host_valid`/`host_byte`). It synchronises and 16× oversamples the line, frames 8N1 characters (optionally 8E1), and buffers received bytes in a small FIFO. The FIFO absorbs the core's multi-cycle stalls during display writes and 100-column scroll clears.

---
 rtl/uart_rx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling RS-232 receiver with a show-ahead byte FIFO.
// Frames 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a live parity_error.
module uart_rx #(
  parameter int unsigned BAUD_DIV   = 14,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       host_ready,
  output logic       host_valid,
  output logic [7:0] host_byte,
  output logic       frame_error,
  output logic       parity_error,
  output logic       overrun
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned DivW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rxs_q, rxs_prev_q;
  logic [1:0]      warm_q;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      s_q, s_d;
  logic [1:0]      smp_q, smp_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            good_q, good_d;
  logic            ferr_q, ferr_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            perr_pulse_q, perr_pulse_d;
`endif

  logic tick, sample_pt, maj, fall, full, push, pop;

  // Two-flop synchroniser plus edge register. warm_q keeps the edge detector blind
  // until rxs_q carries real line data, so a line held low across reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      warm_q     <= 2'b00;
      rxs_prev_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      warm_q     <= {warm_q[0], 1'b1};
      rxs_prev_q <= warm_q[1] ? rxs_q : 1'b0;
    end
  end

  assign fall      = warm_q[1] && rxs_prev_q && !rxs_q;
  assign tick      = (state_q != StIdle) && (div_q == DivMax);
  // Majority is resolved on the tick after the bit centre, using ticks c-1, c, c+1.
  assign sample_pt = tick && (s_q[3:0] == 4'd9);
  assign maj       = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs_q) | (smp_q[0] & rxs_q);

  // Framing FSM, baud divider and sample counter next-state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    s_d     = s_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    good_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    perr_pulse_d = 1'b0;
`endif
    if (state_q != StIdle) begin
      if (tick) begin
        div_d = '0;
        s_d   = s_q + 8'd1;
        smp_d = {smp_q[0], rxs_q};
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          div_d   = '0;
          s_d     = '0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      StStart: begin
        if (sample_pt) state_d = maj ? StIdle : StData;
      end
      StData: begin
        if (sample_pt) begin
          shreg_d = {maj, shreg_q[7:1]};
          if (s_q[7:4] == 4'd8) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample_pt) begin
          perr_d  = maj ^ (^shreg_q);
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (sample_pt) begin
          state_d = StIdle;
          if (!maj) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (perr_q) begin
            perr_pulse_d = 1'b1;
`endif
          end else begin
            good_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Framing state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      s_q     <= '0;
      smp_q   <= 2'b11;
      shreg_q <= '0;
      good_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      perr_pulse_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      smp_q   <= smp_d;
      shreg_q <= shreg_d;
      good_q  <= good_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      perr_pulse_q <= perr_pulse_d;
`endif
    end
  end

  // FIFO control. Full is judged in the push cycle so a same-cycle pop makes room.
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign host_valid = (wr_ptr_q != rd_ptr_q);
  assign pop        = host_valid && host_ready;
  assign push       = good_q && (!full || pop);
  assign overrun    = good_q && full && !pop;
  assign host_byte  = mem_q[rd_ptr_q[AW-1:0]];
  assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_pulse_q;
`else
  assign parity_error = 1'b0;
`endif

  // Pointer next-state; pointers wrap modulo 2*FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV=2 (32-cycle bit time).
// Parity scenarios are built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT = 32;

  logic       clk, reset, rx, host_ready;
  logic       host_valid, frame_error, parity_error, overrun;
  logic [7:0] host_byte;

  int n_vec = 0;
  int n_err = 0;

  // Monitor tallies (written only by the monitor process)
  int         vcyc = 0, fe = 0, pe = 0, ov = 0;
  logic [7:0] got_q[$];

  uart_rx #(.BAUD_DIV(2), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .host_ready   (host_ready),
    .host_valid   (host_valid),
    .host_byte    (host_byte),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (host_valid) vcyc++;
    if (host_valid && host_ready) got_q.push_back(host_byte);
    if (frame_error) fe++;
    if (parity_error) pe++;
    if (overrun) ov++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; holds the line level for one bit time.
  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_with_par(input logic [7:0] d, input logic p);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(p);
    bit_out(1'b1);
  endtask
`endif

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0, fe0, pe0, ov0, b0;

    reset = 1'b1;
    rx = 1'b1;
    host_ready = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4);

    // Reset state
    @(negedge clk);
    chk("rst_valid", host_valid, 0);
    chk("rst_byte", host_byte, 8'h00);
    chk("rst_ferr", frame_error, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ovr", overrun, 0);
    wait_cyc(1);

    // Basic receive of 0x41 with the consumer always ready
    host_ready = 1'b1;
    v0 = vcyc; fe0 = fe; pe0 = pe; ov0 = ov; b0 = got_q.size();
    send(8'h41, 1'b1);
    wait_cyc(8);
    chk("basic_valid_cycles", vcyc - v0, 1);
    chk("basic_count", got_q.size() - b0, 1);
    chk("basic_byte", got_q[b0], 8'h41);
    chk("basic_ferr", fe - fe0, 0);
    chk("basic_perr", pe - pe0, 0);
    chk("basic_ovr", ov - ov0, 0);

    // Glitch: six low cycles must not start a frame
    fe0 = fe; pe0 = pe; ov0 = ov; b0 = got_q.size();
    rx = 1'b0;
    wait_cyc(6);
    rx = 1'b1;
    wait_cyc(400);
    chk("glitch_count", got_q.size() - b0, 0);
    chk("glitch_ferr", fe - fe0, 0);
    chk("glitch_ovr", ov - ov0, 0);
    chk("glitch_valid", host_valid, 0);

    // Fill the FIFO back to back, ninth byte overruns
    host_ready = 1'b0;
    fe0 = fe; ov0 = ov;
    for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
    wait_cyc(8);
    chk("fill_ovr", ov - ov0, 1);
    chk("fill_ferr", fe - fe0, 0);
    chk("fill_valid", host_valid, 1);
    chk("fill_head", host_byte, 8'h00);
    host_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_valid", host_valid, 1);
      chk("drain_byte", host_byte, 8'(i));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain_empty", host_valid, 0);
    wait_cyc(1);

    // Framing error on 0x55, then a good 0x0D
    fe0 = fe; ov0 = ov; b0 = got_q.size();
    send(8'h55, 1'b0);
    bit_out(1'b1);
    chk("ferr_pulse", fe - fe0, 1);
    chk("ferr_count", got_q.size() - b0, 0);
    chk("ferr_valid", host_valid, 0);
    send(8'h0D, 1'b1);
    wait_cyc(8);
    chk("after_ferr_count", got_q.size() - b0, 1);
    chk("after_ferr_byte", got_q[b0], 8'h0D);
    chk("after_ferr_fe", fe - fe0, 1);
    chk("after_ferr_ovr", ov - ov0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x03 has even data parity, so a parity bit of 1 is wrong
    pe0 = pe; fe0 = fe; b0 = got_q.size();
    send_with_par(8'h03, 1'b1);
    wait_cyc(8);
    chk("par_bad_pulse", pe - pe0, 1);
    chk("par_bad_count", got_q.size() - b0, 0);
    send_with_par(8'h03, 1'b0);
    wait_cyc(8);
    chk("par_good_pulse", pe - pe0, 1);
    chk("par_good_count", got_q.size() - b0, 1);
    chk("par_good_byte", got_q[b0], 8'h03);
    chk("par_ferr", fe - fe0, 0);
`endif

    // Reset during data bit 4 of 0x0F with two bytes queued
    host_ready = 1'b0;
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    wait_cyc(4);
    chk("preq_valid", host_valid, 1);
    chk("preq_head", host_byte, 8'hA5);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", host_valid, 0);
    chk("rst_async_byte", host_byte, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    fe0 = fe; pe0 = pe; ov0 = ov; b0 = got_q.size();
    // Rest of bit 4, bits 5..7 low (and parity 0), then stop and idle
    repeat (BIT - 14) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) bit_out(1'b0);
`ifdef UART_RX_PARITY_EN
    bit_out(1'b0);
`endif
    bit_out(1'b1);
    bit_out(1'b1);
    chk("post_rst_valid", host_valid, 0);
    host_ready = 1'b1;
    send(8'h7E, 1'b1);
    wait_cyc(8);
    chk("post_rst_count", got_q.size() - b0, 1);
    chk("post_rst_byte", got_q[b0], 8'h7E);
    chk("post_rst_ferr", fe - fe0, 0);
    chk("post_rst_perr", pe - pe0, 0);
    chk("post_rst_ovr", ov - ov0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
